// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_scan
//  Purpose  : Time-multiplexes four BCD time digits (MM:SS) onto a 4-digit
//             common-anode seven-segment display. Digits are latched once
//             per frame so a frame never shows a mix of old and new time.
//             Adds leading-zero blanking of the minutes-tens digit, a fixed
//             colon dot on slot 2 and per-field blinking for time-set mode.
//  Ports    : clk       - system clock, rising edge
//             reset     - asynchronous reset, active low
//             min_ten, min_one, sec_ten, sec_one - BCD digits in
//             blink_min - blink minutes field (slots 3,2), live input
//             blink_sec - blink seconds field (slots 1,0), live input
//             an[3:0]   - digit enables, active low (an[0] = sec_one)
//             seg[6:0]  - segments g..a, active low
//             dp        - decimal point, active low
//             scan_done - one-cycle pulse at each frame start
//  Revision : 1.0 - initial release
// ============================================================================
module seg_display_scan #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] min_ten,
   input  logic [3:0] min_one,
   input  logic [3:0] sec_ten,
   input  logic [3:0] sec_one,
   input  logic       blink_min,
   input  logic       blink_sec,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       scan_done
);

   localparam int c_PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(REFRESH_DIV - 1);
   localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
   localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
   localparam logic [c_BLINK_W-1:0] c_BLINK_ONE  = c_BLINK_W'(1);

   // Active-low segment patterns, bit order g,f,e,d,c,b,a
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;   // not a BCD digit: dark, digit still enabled
      endcase
      return s;
   endfunction

   logic [c_PRESC_W-1:0] r_presc;
   logic [1:0]           r_idx;
   logic [c_BLINK_W-1:0] r_blink_cnt;
   logic                 r_blink_phase;
   logic [3:0]           r_snap_min_ten;
   logic [3:0]           r_snap_min_one;
   logic [3:0]           r_snap_sec_ten;
   logic [3:0]           r_snap_sec_one;
   logic                 r_scan_done;
   logic [3:0]           r_an;
   logic [6:0]           r_seg;
   logic                 r_dp;

   logic                 w_tick;
   logic                 w_frame_wrap;
   logic [3:0]           w_digit;
   logic [3:0]           w_an_sel;
   logic                 w_blank;

   assign w_tick       = (r_presc == c_PRESC_LAST);
   assign w_frame_wrap = w_tick && (r_idx == 2'd3);

   // Slot prescaler: one tick per REFRESH_DIV clocks
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + c_PRESC_ONE;
      end
   end

   // Digit slot index, 0..3 wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx <= 2'd0;
      end else if (w_tick) begin
         r_idx <= r_idx + 2'd1;
      end
   end

   // Blink half-period timer, clocked by slot ticks
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (w_tick) begin
         if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
         end
      end
   end

   // Frame snapshot: taken on the same edge the index returns to slot 0,
   // so slot 0 of the new frame is already built from the new digits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_snap_min_ten <= 4'd0;
         r_snap_min_one <= 4'd0;
         r_snap_sec_ten <= 4'd0;
         r_snap_sec_one <= 4'd0;
         r_scan_done    <= 1'b0;
      end else begin
         r_scan_done <= w_frame_wrap;
         if (w_frame_wrap) begin
            r_snap_min_ten <= min_ten;
            r_snap_min_one <= min_one;
            r_snap_sec_ten <= sec_ten;
            r_snap_sec_one <= sec_one;
         end
      end
   end

   // Slot content selection and blanking decisions
   always_comb begin
      w_digit  = r_snap_sec_one;
      w_an_sel = 4'b1110;
      case (r_idx)
         2'd0: begin
            w_digit  = r_snap_sec_one;
            w_an_sel = 4'b1110;
         end
         2'd1: begin
            w_digit  = r_snap_sec_ten;
            w_an_sel = 4'b1101;
         end
         2'd2: begin
            w_digit  = r_snap_min_one;
            w_an_sel = 4'b1011;
         end
         default: begin
            w_digit  = r_snap_min_ten;
            w_an_sel = 4'b0111;
         end
      endcase
      // r_idx[1] distinguishes the minutes field (slots 2,3) from seconds
      w_blank = ((r_idx == 2'd3) && (r_snap_min_ten == 4'd0)) ||
                (r_blink_phase && blink_min &&  r_idx[1]) ||
                (r_blink_phase && blink_sec && !r_idx[1]);
   end

   // Registered pin drivers; a blanked slot also forces the dot off
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_an  <= 4'b1111;
         r_seg <= 7'b1111111;
         r_dp  <= 1'b1;
      end else if (w_blank) begin
         r_an  <= 4'b1111;
         r_seg <= 7'b1111111;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_sel;
         r_seg <= bcd_to_seg(w_digit);
         r_dp  <= (r_idx != 2'd2);
      end
   end

   assign an        = r_an;
   assign seg       = r_seg;
   assign dp        = r_dp;
   assign scan_done = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_display_scan
//  Purpose  : Self-checking bench for seg_display_scan. Stimulus pushes
//             hand-computed per-frame expectations into a queue; a monitor
//             pops one entry per scan_done and compares every clock of the
//             following frame. A second instance runs with REFRESH_DIV=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_scan;

   localparam int RD = 4;
   // BLINK_DIV=4 makes each blink half-period exactly one frame, so odd
   // frames (counted from reset) are blanked and even frames are not.
   localparam int BD = 4;

   typedef struct packed {
      logic [15:0] an;    // slot0 in [3:0]
      logic [27:0] seg;   // slot0 in [6:0]
      logic [3:0]  dp;    // slot0 in [0]
   } frame_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] min_ten = 4'd0, min_one = 4'd0, sec_ten = 4'd0, sec_one = 4'd0;
   logic       blink_min = 1'b0, blink_sec = 1'b0;
   logic [3:0] an, f_an;
   logic [6:0] seg, f_seg;
   logic       dp, f_dp, scan_done, f_sd;

   int     n_cmp = 0;
   int     n_err = 0;
   int     frame_no = 0;
   int     chk_left = 0;
   frame_t exp_q[$];
   frame_t cur;
   frame_t fr_a, fr_b, fr_c, fr_d, fr_bs, fr_both, fr_bm;

   always #5 clk = ~clk;

   seg_display_scan #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) u_dut (
      .clk(clk), .reset(reset),
      .min_ten(min_ten), .min_one(min_one), .sec_ten(sec_ten), .sec_one(sec_one),
      .blink_min(blink_min), .blink_sec(blink_sec),
      .an(an), .seg(seg), .dp(dp), .scan_done(scan_done)
   );

   seg_display_scan #(.REFRESH_DIV(1), .BLINK_DIV(1)) u_fast (
      .clk(clk), .reset(reset),
      .min_ten(min_ten), .min_one(min_one), .sec_ten(sec_ten), .sec_one(sec_one),
      .blink_min(blink_min), .blink_sec(blink_sec),
      .an(f_an), .seg(f_seg), .dp(f_dp), .scan_done(f_sd)
   );

   function automatic frame_t frm(input logic [3:0] a0, a1, a2, a3,
                                  input logic [6:0] s0, s1, s2, s3,
                                  input logic [3:0] d);
      frame_t f;
      f.an  = {a3, a2, a1, a0};
      f.seg = {s3, s2, s1, s0};
      f.dp  = d;
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic wait_sd();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 40);
      check("scan_done within bound", {31'd0, scan_done}, 32'd1);
      frame_no++;
   endtask

   // Drive a digit/blink vector and expect nfr consecutive checked frames.
   task automatic apply(input logic [3:0] mt, mo, st, so, input logic bm, bs,
                        input int nfr, input frame_t ev, input frame_t od);
      @(posedge clk);
      #1;
      min_ten = mt; min_one = mo; sec_ten = st; sec_one = so;
      blink_min = bm; blink_sec = bs;
      for (int f = 1; f <= nfr; f++)
         exp_q.push_back((((frame_no + f) % 2) == 1) ? od : ev);
      repeat (nfr + 1) wait_sd();
   endtask

   initial begin
      fr_a    = frm(4'b1110, 4'b1101, 4'b1011, 4'b0111,
                    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1011);
      fr_b    = frm(4'b1110, 4'b1101, 4'b1011, 4'b1111,
                    7'b0010000, 7'b1000000, 7'b0010010, 7'b1111111, 4'b1011);
      fr_c    = frm(4'b1110, 4'b1101, 4'b1011, 4'b0111,
                    7'b1111111, 7'b0010010, 7'b0000010, 7'b0000000, 4'b1011);
      fr_d    = frm(4'b1110, 4'b1101, 4'b1011, 4'b0111,
                    7'b1111000, 7'b0110000, 7'b0100100, 7'b0010000, 4'b1011);
      fr_bs   = frm(4'b1111, 4'b1111, 4'b1011, 4'b0111,
                    7'b1111111, 7'b1111111, 7'b0100100, 7'b1111001, 4'b1011);
      fr_both = frm(4'b1111, 4'b1111, 4'b1111, 4'b1111,
                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 4'b1111);
      fr_bm   = frm(4'b1110, 4'b1101, 4'b1111, 4'b1111,
                    7'b0011001, 7'b0110000, 7'b1111111, 7'b1111111, 4'b1111);

      fork
         begin : stim
            int n;
            // Reset state, before any clock edge
            #1 reset = 1'b0;
            #2;
            check("reset an", {28'd0, an}, 32'hF);
            check("reset seg", {25'd0, seg}, 32'h7F);
            check("reset dp", {31'd0, dp}, 32'd1);
            check("reset scan_done", {31'd0, scan_done}, 32'd0);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            frame_no = 0;
            @(negedge clk);
            check("first slot an", {28'd0, an}, 32'b1110);
            check("first slot seg", {25'd0, seg}, 32'b1000000);

            apply(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 2, fr_a, fr_a);
            apply(4'd0, 4'd5, 4'd0, 4'd9, 1'b0, 1'b0, 3, fr_b, fr_b);
            apply(4'd8, 4'd6, 4'd5, 4'hB, 1'b0, 1'b0, 1, fr_c, fr_c);

            // Input change mid-frame must not tear the frame being shown
            @(posedge clk);
            #1;
            min_ten = 4'd1; min_one = 4'd2; sec_ten = 4'd3; sec_one = 4'd4;
            exp_q.push_back(fr_a);
            wait_sd();
            repeat (2 * RD + 2) @(negedge clk);
            min_ten = 4'd9; sec_one = 4'd7;
            exp_q.push_back(fr_d);
            wait_sd();
            wait_sd();

            apply(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 2, fr_a, fr_bs);
            apply(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 2, fr_a, fr_both);
            apply(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 2, fr_a, fr_bm);
            apply(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1, fr_a, fr_a);

            // Asynchronous reset while slot 2 is displayed
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (an !== 4'b1011 && n < 40);
            check("slot 2 seen before reset", {28'd0, an}, 32'b1011);
            #2 reset = 1'b0;
            #1;
            check("async reset an", {28'd0, an}, 32'hF);
            check("async reset seg", {25'd0, seg}, 32'h7F);
            check("async reset dp", {31'd0, dp}, 32'd1);
            @(negedge clk);
            reset = 1'b1;
            frame_no = 0;
            @(negedge clk);
            check("post reset an", {28'd0, an}, 32'b1110);
            check("post reset seg", {25'd0, seg}, 32'b1000000);

            // REFRESH_DIV=1 instance: digit rotates every clock
            repeat (10) @(negedge clk);
            n = 0;
            while (f_an !== 4'b1110 && n < 8) begin
               @(negedge clk);
               n++;
            end
            check("fast slot0 an", {28'd0, f_an}, 32'b1110);
            check("fast slot0 seg", {25'd0, f_seg}, 32'b0011001);
            @(negedge clk);
            check("fast slot1 an", {28'd0, f_an}, 32'b1101);
            @(negedge clk);
            check("fast slot2 an", {28'd0, f_an}, 32'b1011);
            check("fast slot2 dp", {31'd0, f_dp}, 32'd0);
            @(negedge clk);
            check("fast slot3 an", {28'd0, f_an}, 32'b0111);
            check("fast scan_done", {31'd0, f_sd}, 32'd1);
            @(negedge clk);
            check("fast wrap an", {28'd0, f_an}, 32'b1110);

            repeat (4) @(negedge clk);
            check("expectations drained", exp_q.size(), 32'd0);
            check("frame checks complete", chk_left, 32'd0);
         end
         begin : mon
            int slot;
            forever begin
               @(negedge clk);
               if (!reset) begin
                  chk_left = 0;
               end else begin
                  if (chk_left > 0) begin
                     slot = (4 * RD - chk_left) / RD;
                     n_cmp++;
                     if (an !== cur.an[slot*4 +: 4] || seg !== cur.seg[slot*7 +: 7] ||
                         dp !== cur.dp[slot]) begin
                        n_err++;
                        $display("FAIL frame slot%0d @%0t: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                                 slot, $time, an, seg, dp, cur.an[slot*4 +: 4],
                                 cur.seg[slot*7 +: 7], cur.dp[slot]);
                     end
                     chk_left--;
                  end
                  if (scan_done && exp_q.size() > 0) begin
                     cur = exp_q.pop_front();
                     chk_left = 4 * RD;
                  end
               end
            end
         end
      join_any
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
- Downstream consumer of the time-keeping counter's four BCD digits (min_ten, min_one, sec_ten, sec_one).
- Time-multiplexes those digits onto a 4-digit common-anode seven-segment display.
- Adds frame-coherent snapshotting, leading-zero blanking, a fixed colon dot and per-field blink for time-set mode.
- Sits between the counter and the board display pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (100 MHz gives a 1 kHz slot rate). Minimum 1.
- BLINK_DIV, 250: slot ticks per blink half-period. Minimum 1.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- min_ten  in  4  BCD minutes tens digit.
- min_one  in  4  BCD minutes ones digit.
- sec_ten  in  4  BCD seconds tens digit.
- sec_one  in  4  BCD seconds ones digit.
- blink_min  in  1  blink the minutes field (digits 3,2).
- blink_sec  in  1  blink the seconds field (digits 1,0).
- an  out  4  digit enables, active-low. an[0]=sec_one, an[1]=sec_ten, an[2]=min_one, an[3]=min_ten.
- seg  out  7  segment cathodes, active-low. seg[6:0]=g,f,e,d,c,b,a.
- dp  out  1  decimal point, active-low.
- scan_done  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-scan):
  - an=4'b1111, seg=7'b1111111, dp=1, scan_done=0.
  - Prescaler=0, digit index=0, blink counter=0, blink_phase=0, digit snapshot=all 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted in the cycle where count==REFRESH_DIV-1.
  - With REFRESH_DIV=1, tick is asserted every cycle.
- Digit index:
  - 2-bit counter; advances on tick, sequence 0,1,2,3,0.
- Snapshot:
  - On the tick that moves the index 3->0, all four input digits are latched into the snapshot.
  - The display reads only the snapshot, so input changes never tear within a frame.
  - scan_done is pulsed in the cycle after that tick.
- Output registers:
  - an, seg and dp are registered from index and snapshot.
  - They are valid 1 clk after each index change.
  - Each digit is held for exactly REFRESH_DIV clks.
- Decode (value -> seg, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 (invalid BCD) = 1111111, blank; the digit enable still asserts.
- Leading-zero blanking:
  - When snapshot min_ten==0, slot 3 drives an=4'b1111 and seg=7'b1111111.
- Colon dot:
  - dp=0 only during slot 2; dp=1 in all other slots.
- Blink:
  - The blink counter counts ticks 0..BLINK_DIV-1 and toggles blink_phase at wrap.
  - When blink_phase=1 and blink_min=1, slots 2 and 3 drive an=4'b1111, seg all 1, dp=1.
  - When blink_phase=1 and blink_sec=1, slots 0 and 1 are blanked the same way.
  - Both blink inputs may be active at once; all four digits then blank together.
  - blink_min and blink_sec are sampled live, not snapshotted.
- Outputs are never X after reset release. The first slot shown is slot 0 with snapshot=0, so sec_one displays "0".

Test Plan (REFRESH_DIV=4, BLINK_DIV=2 unless stated):
- Reset mid-operation: drive reset=0 while an=4'b1011 -> an=4'b1111 and seg=7'b1111111 in the same cycle, before any clk edge. After release, slot 0 appears with seg=1000000.
- Digits 1,2,3,4 (min_ten..sec_one), held over 2 frames:
  - Second frame an sequence = 1110, 1101, 1011, 0111, each for 4 clks.
  - seg = 0011001, 0110000, 0100100, 1111001 respectively.
  - dp=0 only while an=1011.
- min_ten=0, min_one=5 -> an[3] is never 0 over 3 frames; slot 2 shows seg=0010010.
- Change sec_one 4->7 during slot 2 -> slot 0 keeps showing 0011001 until after the next scan_done pulse, then shows 1111000.
- blink_sec=1 -> slots 0 and 1 blank (an=1111) during alternating 2-tick windows; slots 2 and 3 are unaffected.
- sec_one=4'hB -> while an=4'b1110, seg=7'b1111111.
- REFRESH_DIV=1 -> tick every clk; an rotates every clk.
